// File: rtl/cs_pkg.sv
// Shared definitions for the sliding-window approximate-average filter.
// Provides the mode encodings and the derived-width helpers used by the
// top level and the approximate-value selector.
package cs_pkg;

  // Runtime selection of the approximate value taken from the window.
  typedef enum logic [1:0] {
    CS_MODE_FLOOR = 2'd0,
    CS_MODE_CEIL  = 2'd1,
    CS_MODE_AVG   = 2'd2,
    CS_MODE_RSVD  = 2'd3
  } cs_mode_e;

  // Running-sum width: enough headroom for WIN full-scale samples.
  function automatic int unsigned cs_sum_w(input int unsigned data_w,
                                           input int unsigned win);
    return data_w + $clog2(win + 1);
  endfunction

  // Output width: (sum + WIN*A) needs one bit over the sum, minus the shift.
  function automatic int unsigned cs_y_w(input int unsigned sum_w,
                                         input int unsigned shift);
    return sum_w + 1 - shift;
  endfunction

endpackage

// File: rtl/cs_approx_select.sv
// Combinational selector of the approximate window value.
// Ports:
//   win_i    flattened window, entry i at bits [i*DATA_W +: DATA_W]
//   avg_i    floor(sum / WIN)
//   mode_i   floor / ceil / average select (reserved code behaves as floor)
//   approx_c selected approximate value A
module cs_approx_select
  import cs_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned WIN    = 9
) (
  input  logic [WIN*DATA_W-1:0] win_i,
  input  logic [DATA_W-1:0]     avg_i,
  input  logic [1:0]            mode_i,
  output logic [DATA_W-1:0]     approx_c
);

  logic [DATA_W-1:0] entry;
  logic [DATA_W-1:0] floor_val;
  logic [DATA_W-1:0] ceil_val;

  // Largest entry <= avg and smallest entry >= avg. The window minimum is
  // always <= avg and the maximum always >= avg, so both seeds get replaced.
  always_comb begin
    entry     = '0;
    floor_val = '0;
    ceil_val  = '1;
    for (int i = 0; i < int'(WIN); i++) begin
      entry = win_i[i*DATA_W +: DATA_W];
      if (entry <= avg_i && entry >= floor_val) floor_val = entry;
      if (entry >= avg_i && entry <= ceil_val)  ceil_val  = entry;
    end
  end

  always_comb begin
    approx_c = floor_val;
    case (cs_mode_e'(mode_i))
      CS_MODE_CEIL: approx_c = ceil_val;
      CS_MODE_AVG:  approx_c = avg_i;
      default:      approx_c = floor_val;
    endcase
  end

endmodule

// File: rtl/cs_window_filter.sv
// Sliding-window approximate-average filter.
// Keeps the last WIN accepted samples and their running sum; one cycle after
// each accept that leaves the window full, registers
// Y = (sum + WIN*A) >> SHIFT, with A chosen by mode, and pulses out_valid.
// Ports:
//   clk, reset (async active-low), clear (sync flush of window/sum/fill)
//   in_valid, X   sample accept and data
//   mode          0 floor, 1 ceil, 2 average, 3 as floor (sampled at result)
//   Y, out_valid  registered result and one-cycle valid pulse
module cs_window_filter
  import cs_pkg::*;
#(
  parameter  int unsigned DATA_W = 8,
  parameter  int unsigned WIN    = 9,
  parameter  int unsigned SHIFT  = 3,
  localparam int unsigned SUM_W  = cs_sum_w(DATA_W, WIN),
  localparam int unsigned Y_W    = cs_y_w(SUM_W, SHIFT)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] X,
  input  logic [1:0]        mode,
  output logic [Y_W-1:0]    Y,
  output logic              out_valid
);

  localparam int unsigned FILL_W = $clog2(WIN + 1);
  localparam int unsigned WBITS  = WIN * DATA_W;
  localparam int unsigned RES_W  = SUM_W + 1;

  logic [WBITS-1:0]  win_q, win_d;
  logic [SUM_W-1:0]  sum_q, sum_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              pend_q, pend_d;
  logic [Y_W-1:0]    y_q, y_d;
  logic              vld_q;
  logic [DATA_W-1:0] oldest;
  logic [DATA_W-1:0] avg;
  logic [DATA_W-1:0] approx;
  logic [RES_W-1:0]  res;

  // Accept path: newest sample enters at the low end, oldest leaves the top.
  always_comb begin
    oldest = win_q[WBITS-1 -: DATA_W];
    win_d  = {win_q[WBITS-DATA_W-1:0], X};
    sum_d  = sum_q + SUM_W'(X) - SUM_W'(oldest);
    fill_d = (fill_q == FILL_W'(WIN)) ? fill_q : fill_q + FILL_W'(1);
    pend_d = in_valid && (fill_d == FILL_W'(WIN));
  end

  // Result path works on the registered window, one cycle after the accept.
  assign avg = DATA_W'(sum_q / SUM_W'(WIN));

  cs_approx_select #(
    .DATA_W (DATA_W),
    .WIN    (WIN)
  ) u_sel (
    .win_i    (win_q),
    .avg_i    (avg),
    .mode_i   (mode),
    .approx_c (approx)
  );

  assign res = RES_W'(sum_q) + RES_W'(WIN * approx);
  assign y_d = Y_W'(res >> SHIFT);

  // Clear drops the sample and any pending result but keeps Y.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      win_q  <= '0;
      sum_q  <= '0;
      fill_q <= '0;
      pend_q <= 1'b0;
      vld_q  <= 1'b0;
      y_q    <= '0;
    end else if (clear) begin
      win_q  <= '0;
      sum_q  <= '0;
      fill_q <= '0;
      pend_q <= 1'b0;
      vld_q  <= 1'b0;
    end else begin
      if (in_valid) begin
        win_q  <= win_d;
        sum_q  <= sum_d;
        fill_q <= fill_d;
      end
      pend_q <= pend_d;
      vld_q  <= pend_q;
      if (pend_q) y_q <= y_d;
    end
  end

  assign Y         = y_q;
  assign out_valid = vld_q;

endmodule

// File: tb/tb_cs_window_filter.sv
// Directed self-checking bench for cs_window_filter at default parameters.
module tb_cs_window_filter;

  logic       clk;
  logic       reset;
  logic       clear;
  logic       in_valid;
  logic [7:0] X;
  logic [1:0] mode;
  logic [9:0] Y;
  logic       out_valid;

  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned pulses;
  int unsigned ylast;

  cs_window_filter dut (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .in_valid  (in_valid),
    .X         (X),
    .mode      (mode),
    .Y         (Y),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock with the given inputs; returns #1 after the edge.
  task automatic drive(input int unsigned x, input bit v, input bit c);
    X        = 8'(x);
    in_valid = v;
    clear    = c;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    clear    = 1'b0;
  endtask

  // Same as drive, also tallying out_valid pulses and the last Y seen.
  task automatic drive_cnt(input int unsigned x, input bit v);
    drive(x, v, 1'b0);
    if (out_valid) begin
      pulses++;
      ylast = int'(Y);
    end
  endtask

  // Eight zeros then 90; mode switched to m only for the result edge.
  task automatic mode_case(input string tag, input logic [1:0] m,
                           input logic [1:0] other, input int unsigned exp);
    drive(0, 1'b0, 1'b1);
    mode = other;
    for (int i = 0; i < 8; i++) drive(0, 1'b1, 1'b0);
    drive(90, 1'b1, 1'b0);
    mode = m;
    drive(0, 1'b0, 1'b0);
    chk({tag, "_valid"}, int'(out_valid), 1);
    chk({tag, "_y"}, int'(Y), exp);
    mode = 2'd0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset    = 1'b0;
    clear    = 1'b0;
    in_valid = 1'b0;
    X        = '0;
    mode     = 2'd0;
    #1;
    chk("reset_y", int'(Y), 0);
    chk("reset_valid", int'(out_valid), 0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Warm-up: eight 10s silent, ninth produces Y=22 one cycle later.
    pulses = 0;
    for (int i = 0; i < 9; i++) drive_cnt(10, 1'b1);
    chk("warmup_silent", pulses, 0);
    drive(0, 1'b0, 1'b0);
    chk("warmup_valid", int'(out_valid), 1);
    chk("warmup_y", int'(Y), 22);
    drive(0, 1'b0, 1'b0);
    chk("warmup_pulse_len", int'(out_valid), 0);

    // Modes on {0 x8, 90}: sum 90, avg 10.
    mode_case("mode_floor", 2'd0, 2'd1, 11);
    mode_case("mode_ceil",  2'd1, 2'd2, 112);
    mode_case("mode_avg",   2'd2, 2'd0, 22);
    mode_case("mode_rsvd",  2'd3, 2'd1, 11);

    // Full scale, then a 0 pushed back-to-back.
    drive(0, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) drive(255, 1'b1, 1'b0);
    drive(0, 1'b1, 1'b0);
    chk("full_valid", int'(out_valid), 1);
    chk("full_y", int'(Y), 573);
    drive(0, 1'b0, 1'b0);
    chk("full_push0_valid", int'(out_valid), 1);
    chk("full_push0_y", int'(Y), 255);

    // Gaps: 1..4, three idle cycles, 5..9.
    drive(0, 1'b0, 1'b1);
    pulses = 0;
    ylast  = 0;
    for (int k = 1; k <= 4; k++) drive_cnt(k, 1'b1);
    for (int k = 0; k < 3; k++) drive_cnt(0, 1'b0);
    for (int k = 5; k <= 9; k++) drive_cnt(k, 1'b1);
    chk("gap_before_last", pulses, 0);
    for (int k = 0; k < 3; k++) drive_cnt(0, 1'b0);
    chk("gap_pulses", pulses, 1);
    chk("gap_y", ylast, 11);

    // Clear while streaming suppresses the pending result and forces refill.
    drive(0, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) drive(10, 1'b1, 1'b0);
    drive(10, 1'b1, 1'b0);
    chk("stream_valid", int'(out_valid), 1);
    chk("stream_y", int'(Y), 22);
    drive(10, 1'b1, 1'b0);
    chk("stream_valid2", int'(out_valid), 1);
    drive(99, 1'b1, 1'b1);
    chk("clear_suppress", int'(out_valid), 0);
    chk("clear_y_hold", int'(Y), 22);
    pulses = 0;
    for (int i = 0; i < 9; i++) drive_cnt(20, 1'b1);
    chk("clear_refill_silent", pulses, 0);
    drive(0, 1'b0, 1'b0);
    chk("clear_refill_valid", int'(out_valid), 1);
    chk("clear_refill_y", int'(Y), 45);

    // Asynchronous reset mid-stream.
    for (int i = 0; i < 10; i++) drive(30, 1'b1, 1'b0);
    chk("prereset_valid", int'(out_valid), 1);
    chk("prereset_y", int'(Y), 67);
    #2;
    reset = 1'b0;
    #1;
    chk("async_reset_y", int'(Y), 0);
    chk("async_reset_valid", int'(out_valid), 0);
    @(posedge clk);
    #1;
    reset  = 1'b1;
    pulses = 0;
    for (int i = 0; i < 9; i++) drive_cnt(30, 1'b1);
    chk("reset_refill_silent", pulses, 0);
    drive(0, 1'b0, 1'b0);
    chk("reset_refill_valid", int'(out_valid), 1);
    chk("reset_refill_y", int'(Y), 67);

    // Ramp 0..20, floor mode: result for sample n is (18n-72)>>3 for n>=8.
    drive(0, 1'b0, 1'b1);
    mode = 2'd0;
    for (int n = 0; n <= 20; n++) begin
      drive(n, 1'b1, 1'b0);
      if (n >= 9) begin
        chk($sformatf("ramp_valid_%0d", n - 1), int'(out_valid), 1);
        chk($sformatf("ramp_y_%0d", n - 1), int'(Y), (18 * (n - 1) - 72) >> 3);
      end else begin
        chk($sformatf("ramp_idle_%0d", n), int'(out_valid), 0);
      end
    end
    drive(0, 1'b0, 1'b0);
    chk("ramp_valid_20", int'(out_valid), 1);
    chk("ramp_y_20", int'(Y), 36);
    drive(0, 1'b0, 1'b0);
    chk("ramp_end", int'(out_valid), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cs_window_filter.md
# cs_window_filter

Parametrised sliding-window approximate-average filter: keeps the last WIN accepted samples and a running sum. Per accepted sample it selects an approximate value from the window by mode (floor, ceil or plain average) and outputs a registered result with a valid flag. Next-generation replacement for the fixed 9-tap, 8-bit, always-on filter in the sample-processing datapath. Adds width/depth parameters, an input valid, warm-up gating, a synchronous clear and runtime mode select.

## Interface
- DATA_W, 8: sample width (unsigned), 4..16
- WIN, 9: window depth, 2..32
- SHIFT, 3: output right-shift
- SUM_W, DATA_W+$clog2(WIN+1): running-sum width (derived, not overridden)
- Y_W, SUM_W+1-SHIFT: output width (derived; 10 at defaults)
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- clear  in  1  synchronous flush of window/sum/fill count
- in_valid  in  1  X is accepted this cycle
- X  in  DATA_W  input sample, unsigned
- mode  in  2  0 = floor, 1 = ceil, 2 = average, 3 = treated as 0
- Y  out  Y_W  filtered result
- out_valid  out  1  one-cycle pulse, Y updated

## Operation
- Reset (reset low) clears everything: window entries, sum, fill count, Y, out_valid all 0.
- Accept: on an edge with in_valid=1 and clear=0:
  - sum <= sum + X - oldest;
  - shift the window (oldest dropped, X newest);
  - fill <= min(fill+1, WIN), saturating.
- Idle: with in_valid=0 the window, sum and fill hold. No output is produced.
- Clear: clear=1 zeroes window, sum, fill and out_valid at the edge. It dominates in_valid; that sample is dropped. Y holds its value.
- avg = floor(sum / WIN), computed from the registered window by constant division. avg fits DATA_W.
- Approximate value A is computed over all WIN entries:
  - floor mode: the largest entry ≤ avg. The minimum entry is always ≤ avg, so A is always defined.
  - ceil mode: the smallest entry ≥ avg.
  - average mode: A = avg.
- Result: Y = (sum + WIN*A) >> SHIFT. Intermediate width is SUM_W+1 bits, so there is no overflow.
- Warm-up: out_valid pulses only for accepts that leave fill == WIN. Before that, Y and out_valid stay unchanged/0.
- mode is sampled when the result is registered, not when the sample is accepted.

## Timing
- Sample accepted at edge E. Window and sum update at E. Y and out_valid register at E+1.
- Latency is 1 cycle after acceptance; throughput is 1 sample/cycle with no backpressure.
- Back-to-back accepts give back-to-back out_valid pulses. out_valid is high for exactly one cycle per qualifying accept.
- clear at edge E+1, following an accept at E, suppresses that pending out_valid.
- The first out_valid after reset or clear comes one cycle after the WIN-th accept.
- Reset asserted mid-stream takes effect immediately (asynchronous). A full WIN-sample refill is required afterwards.

## Structure
- Package cs_pkg holds:
  - mode encodings CS_MODE_FLOOR / CS_MODE_CEIL / CS_MODE_AVG;
  - width helper functions for SUM_W and Y_W.
- Sub-module cs_approx_select: combinational. Inputs are the flattened window, avg and mode; output is A.
- The top level owns the shift register, running sum, fill counter, delayed accept flag and output register.

## Test plan
All cases use defaults (DATA_W=8, WIN=9, SHIFT=3).
- Warm-up: feed 8 samples of 10 → out_valid never asserts. Feed a 9th sample of 10 → one cycle later out_valid=1, Y=(90+90)>>3=22.
- Modes: window of eight 0s then 90 (sum 90, avg 10):
  - floor → Y=11;
  - ceil → Y=(90+810)>>3=112;
  - average → Y=22;
  - mode=3 → Y=11.
- Full scale: nine samples of 255 → Y=(2295+2295)>>3=573. Then push 0 → sum 2040, avg 226, floor A=0, Y=255.
- Gaps: samples 1..9 with in_valid deasserted 3 cycles between samples 4 and 5 → exactly one out_valid, after sample 9. Sum 45, avg 5, A=5, Y=(45+45)>>3=11.
- Clear/reset: full window streaming, then pulse clear → out_valid stops. Eight further samples give no output; the ninth does. Repeat with reset low mid-stream → Y=0 and out_valid=0 asynchronously.
- Sliding: continuous ramp 0,1,2,…,20 → the out_valid following sample n (n≥8) carries sum = 9n−36 and the matching floor-mode Y. Check every cycle against a reference model.
